// File: rtl/ofdm_fp_pkg.sv
// ofdm_fp_pkg
//   Shared single-precision float definitions for the OFDM fixed/float
//   datapath (vec_norm_sq produces, inv_sqrt consumes).
//   Contents: FP32 field widths and exponent bias, fp32_t packed struct.
package ofdm_fp_pkg;

    localparam int FP_BIAS   = 127;
    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
    } fp32_t;

endpackage

// File: rtl/lead_one_det.sv
// lead_one_det
//   Combinational priority encoder: position of the most significant set
//   bit of din.
//   Ports:
//     din   in   W      input word
//     pos   out  POS_W  index of the leading one (0 when din is zero)
//     zero  out  1      din is all zeros
module lead_one_det #(
    parameter int W     = 8,
    parameter int POS_W = $clog2(W)
) (
    input  logic [W-1:0]     din,
    output logic [POS_W-1:0] pos,
    output logic             zero
);

    // Ascending scan: the last hit is the highest set bit.
    always_comb begin
        pos = '0;
        for (int i = 0; i < W; i++) begin
            if (din[i]) pos = POS_W'(i);
        end
    end

    assign zero = ~|din;

endmodule

// File: rtl/vec_norm_sq.sv
// vec_norm_sq
//   Streaming squared-norm engine. Accumulates sum(re^2 + im^2) over
//   VEC_LEN complex Q1.(I_DATA-1) samples exactly in fixed point and
//   emits the result as a float32 (truncated mantissa) for inv_sqrt.
//   Ports:
//     clk        in   1       clock, rising edge
//     reset      in   1       synchronous reset, active low
//     enable     in   1       input acceptance gate
//     in_valid   in   1       sample present on in_re/in_im
//     in_re      in   I_DATA  real part, signed
//     in_im      in   I_DATA  imaginary part, signed
//     odata      out  O_DATA  float32 squared norm, held between pulses
//     out_valid  out  1       one-cycle pulse per completed vector
//     busy       out  1       partial vector held or pipeline occupied
module vec_norm_sq
    import ofdm_fp_pkg::*;
#(
    parameter int I_DATA  = 16,
    parameter int VEC_LEN = 4,
    parameter int O_DATA  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [I_DATA-1:0] in_re,
    input  logic [I_DATA-1:0] in_im,
    output logic [O_DATA-1:0] odata,
    output logic              out_valid,
    output logic              busy
);

    localparam int SQ_W   = 2 * I_DATA;
    localparam int ACC_W  = SQ_W + $clog2(VEC_LEN);
    localparam int POS_W  = $clog2(ACC_W);
    localparam int CNT_W  = $clog2(VEC_LEN);
    localparam int FRAC_W = 2 * (I_DATA - 1);
    localparam logic [FP_EXP_W-1:0] EXP_OFF = FP_EXP_W'(FP_BIAS - FRAC_W);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(VEC_LEN - 1);

    logic accept;
    assign accept = enable & in_valid;

    // Element counter; VEC_LEN is a power of two so it wraps naturally.
    logic [CNT_W-1:0] cnt;

    // Stage 1: squares
    logic signed [SQ_W-1:0] re_ext, im_ext, re_sq, im_sq;
    logic                   s1_valid, s1_first, s1_last;
    logic [SQ_W-1:0]        s1_re2, s1_im2;

    assign re_ext = SQ_W'($signed(in_re));
    assign im_ext = SQ_W'($signed(in_im));
    assign re_sq  = re_ext * re_ext;
    assign im_sq  = im_ext * im_ext;

    // Stage 2: accumulate
    logic [ACC_W-1:0] mag, acc;
    logic             s2_valid, s2_last;

    assign mag = ACC_W'(s1_re2) + ACC_W'(s1_im2);

    // Stage 3: leading-one snapshot of the finished sum
    logic [POS_W-1:0] lod_pos, s3_pos;
    logic             lod_zero, s3_zero, s3_valid;
    logic [ACC_W-1:0] s3_acc;

    lead_one_det #(
        .W     (ACC_W),
        .POS_W (POS_W)
    ) u_lod (
        .din  (acc),
        .pos  (lod_pos),
        .zero (lod_zero)
    );

    // Stage 4: float packing
    fp32_t            fp_c, s4_fp;
    logic             s4_valid;
    logic [POS_W-1:0] shamt;

    assign shamt = POS_W'(ACC_W - 1) - s3_pos;

    always_comb begin
        fp_c = '0;
        if (!s3_zero) begin
            fp_c.sign = 1'b0;
            fp_c.exp  = FP_EXP_W'(s3_pos) + EXP_OFF;
            // Push the leading one to the top of an ACC_W+23 window, then
            // drop it: what remains below is the mantissa, truncated.
            fp_c.mant = FP_MANT_W'(({s3_acc, {FP_MANT_W{1'b0}}} << shamt) >> (ACC_W - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= '0;
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_re2    <= '0;
            s1_im2    <= '0;
            acc       <= '0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            s3_valid  <= 1'b0;
            s3_zero   <= 1'b0;
            s3_pos    <= '0;
            s3_acc    <= '0;
            s4_valid  <= 1'b0;
            s4_fp     <= '0;
            out_valid <= 1'b0;
            odata     <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                cnt      <= cnt + 1'b1;
                s1_first <= (cnt == '0);
                s1_last  <= (cnt == CNT_LAST);
                s1_re2   <= re_sq;
                s1_im2   <= im_sq;
            end

            s2_valid <= s1_valid;
            s2_last  <= s1_valid & s1_last;
            if (s1_valid) acc <= s1_first ? mag : acc + mag;

            s3_valid <= s2_last;
            if (s2_last) begin
                s3_pos  <= lod_pos;
                s3_zero <= lod_zero;
                s3_acc  <= acc;
            end

            s4_valid <= s3_valid;
            if (s3_valid) s4_fp <= fp_c;

            out_valid <= s4_valid;
            if (s4_valid) odata <= O_DATA'(s4_fp);
        end
    end

    assign busy = (cnt != '0) | s1_valid | s2_valid | s3_valid | s4_valid;

endmodule

// File: doc/vec_norm_sq.md
# vec_norm_sq

Streaming squared-norm engine that produces the IEEE-754 single-precision operand for the `inv_sqrt` pipeline. Accepts VEC_LEN complex fixed-point samples per vector, accumulates Σ(re² + im²) exactly in fixed point, then converts the sum to float32. `odata`/`out_valid` connect directly to `inv_sqrt` `idata`/`enable` in the QR/channel-normalisation datapath.

## Interface
- `I_DATA`, 16: width of each signed Q1.(I_DATA-1) component.
- `VEC_LEN`, 4: complex elements per vector; power of two, ≥ 2.
- `O_DATA`, 32: output width; fixed at 32 (float32).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low reset (sampled on `clk`; 0 = reset).
- `enable`  in  1  input-acceptance gate.
- `in_valid`  in  1  element present on `in_re`/`in_im`.
- `in_re`  in  I_DATA  real part, signed two's complement.
- `in_im`  in  I_DATA  imaginary part, signed two's complement.
- `odata`  out  32  float32 ‖v‖², sign bit always 0.
- `out_valid`  out  1  one-cycle pulse, `odata` new this cycle.
- `busy`  out  1  partial vector held or pipeline stage occupied.

## Operation
- Element accepted on a rising edge where `reset`=1, `enable`=1, `in_valid`=1. `enable`=0 blocks acceptance only; in-flight stages keep draining.
- Element counter: 0..VEC_LEN-1, advances per accepted element, wraps to 0 after VEC_LEN-1. Accepted elements need not be contiguous.
- Stage 1: register `in_re²` and `in_im²` (2·I_DATA-bit unsigned each), plus `first`/`last` flags from the counter.
- Stage 2: mag = re² + im². Accumulator ACC_W = 2·I_DATA + log2(VEC_LEN) bits unsigned. `first` loads mag, otherwise adds. Never overflows: the -1.0 × -1.0 corner is exact.
- Stage 3 (on `last` only): leading-one position p of the accumulator, p in 0..ACC_W-1. Register p and the accumulator copy.
- Stage 4: pack the float. Sum value = acc · 2^-(2·(I_DATA-1)).
  - acc = 0: `odata` = 32'h0000_0000.
  - Otherwise: exponent = p − 2·(I_DATA−1) + 127. Mantissa = bits below the leading one, left-aligned to 23 bits, zero-padded or truncated (round toward zero).
- `odata` holds its value between pulses. `out_valid` = 1 for exactly one cycle per completed vector.
- `busy` = (counter ≠ 0) OR any stage-valid flag set.

## Timing
- Reset: `odata`=0, `out_valid`=0, `busy`=0, counter=0, accumulator=0, all stage-valid flags cleared. Reset overrides acceptance on the same edge.
- Reset mid-vector or mid-pipeline discards the partial sum; no pulse is emitted for it.
- Latency: last element accepted at edge t → `out_valid`=1 in the cycle after edge t+4 (4 cycles).
- Throughput: 1 element/cycle. Back-to-back vectors need no bubble; the first element of the next vector loads the accumulator while the previous sum is in stages 3–4.
- Minimum spacing between `out_valid` pulses = VEC_LEN cycles.

## Structure
- Shared package `ofdm_fp_pkg`:
  - FP32 constants: `FP_BIAS`=127, `FP_EXP_W`=8, `FP_MANT_W`=23.
  - `fp32_t` packed struct {sign, exp, mant}. `inv_sqrt` uses the same struct.
- Sub-module `lead_one_det`:
  - Parameterised width, combinational priority encoder.
  - Outputs position and a `zero` flag.
  - Used in stage 3.

## Test plan
- Four elements re=16'h4000, im=0 → `odata`=32'h3F80_0000 (1.0); `out_valid` exactly 4 cycles after the 4th acceptance.
- Four all-zero elements → `odata`=32'h0000_0000, single `out_valid` pulse.
- Four elements re=im=16'h8000 → `odata`=32'h4100_0000 (8.0); no overflow.
- One element re=16'h0001, three zero elements → `odata`=32'h3080_0000 (2^-30). Also a sum with >23 bits below the leading one: check truncation against a reference model.
- Eight consecutive elements: vector A as in case 1, then vector B with re=im=16'h2000 → 32'h3F80_0000 then 32'h3F00_0000, pulses exactly 4 cycles apart. Repeat with `in_valid`/`enable` gaps inserted → same values, delayed by the gap count.
- `reset`=0 for one cycle after 2 elements, then a full case-1 vector → only one pulse, value 32'h3F80_0000; `busy` low right after reset.
